// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of control_unit.
// Owns the program counter and fetches one 16-bit word per step over a
// req/rvalid handshake. Each word is held for a fixed execute window. At the
// end of the window the next PC is chosen from control_unit's jump decision.
module fetch_unit #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter int          EXEC_CYCLES = 2,
   parameter int          MAX_WAIT    = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        set_pc,
   input  logic [15:0] jump_target,
   input  logic [15:0] imem_rdata,
   input  logic        imem_rvalid,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   output logic [15:0] pc,
   output logic [15:0] instr,
   output logic        instr_valid,
   output logic [15:0] retired,
   output logic        fetch_err
);

   // Each counter only needs to hold (limit - 1), so it is sized to that value.
   localparam int EW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
   localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

   localparam logic [EW-1:0] EXEC_LAST = EW'(EXEC_CYCLES - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
   localparam logic [EW-1:0] EXEC_ONE  = EW'(1);
   localparam logic [WW-1:0] WAIT_ONE  = WW'(1);

   // This is a C-type word with no destination and no jump. The core treats it as a NOP.
   localparam logic [15:0] NOP = 16'h0000;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_EXEC,
      S_HALT
   } state_t;

   state_t        state;
   logic [WW-1:0] wait_cnt;
   logic [EW-1:0] exec_cnt;

   // The request is a pulse decoded from the registered state. Stall gates it directly, so no request leaks out while frozen.
   assign imem_req  = (state == S_REQ) && !stall;
   assign imem_addr = pc;

   // Fetch sequencer: request, wait for data (with timeout), hold for the execute window, then step the PC.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_REQ;
         pc          <= RESET_PC;
         instr       <= NOP;
         instr_valid <= 1'b0;
         retired     <= 16'h0000;
         fetch_err   <= 1'b0;
         wait_cnt    <= '0;
         exec_cnt    <= '0;
      end else begin
         case (state)
            S_REQ: begin
               if (!stall) begin
                  wait_cnt <= '0;
                  state    <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (imem_rvalid) begin
                  instr       <= imem_rdata;
                  instr_valid <= 1'b1;
                  exec_cnt    <= EXEC_LAST;
                  state       <= S_EXEC;
               end else if (wait_cnt == WAIT_LAST) begin
                  fetch_err <= 1'b1;
                  instr     <= NOP;
                  state     <= S_HALT;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_ONE;
               end
            end

            S_EXEC: begin
               if (!stall) begin
                  if (exec_cnt != '0) begin
                     exec_cnt <= exec_cnt - EXEC_ONE;
                  end else begin
                     pc          <= set_pc ? jump_target : pc + 16'd1;
                     retired     <= retired + 16'd1;
                     instr_valid <= 1'b0;
                     state       <= S_REQ;
                  end
               end
            end

            S_HALT: begin
               instr_valid <= 1'b0;
               fetch_err   <= 1'b1;
            end

            default: begin
               state <= S_REQ;
            end
         endcase
      end
   end

endmodule
